// File: rtl/binary_threshold_ctrl.sv
// Per-frame threshold controller: accumulates gray statistics between VS edges, divides for
// the frame mean and issues the next frame's binarisation threshold (auto mean+offset or manual).
module binary_threshold_ctrl #(
    parameter int GRAY_W     = 8,
    parameter int CNT_W      = 22,
    parameter int THR_INIT   = 128,
    parameter int MIN_PIXELS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VGA_VS,
    input  logic              GRAY_VALID,
    input  logic [GRAY_W-1:0] GRAY_IN,
    input  logic              BINARY_FLAG_IN,
    input  logic              MODE_AUTO,
    input  logic [GRAY_W-1:0] MANUAL_THRESHOLD,
    input  logic [GRAY_W:0]   OFFSET,
    output logic [GRAY_W-1:0] THRESHOLD_OUT,
    output logic              THRESHOLD_UPDATE,
    output logic [GRAY_W-1:0] MEAN_OUT,
    output logic [CNT_W-1:0]  WHITE_COUNT,
    output logic              BUSY,
    output logic              FRAME_DROP,
    output logic              OVERFLOW
);

    localparam int SUM_W = CNT_W + GRAY_W;
    localparam int IDX_W = (GRAY_W > 1) ? $clog2(GRAY_W) : 1;

    typedef enum logic [1:0] {S_WAIT, S_DIV, S_UPD} state_t;

    state_t             state;
    state_t             state_nxt;

    logic               vs_d;
    logic               armed;
    logic               vs_edge;
    logic               frame_edge;

    logic [SUM_W-1:0]   sum_acc;
    logic [CNT_W-1:0]   cnt_acc;
    logic [CNT_W-1:0]   white_acc;
    logic               bad_acc;
    logic               pix_take;
    logic               cnt_full;
    logic               white_full;
    logic               sat_hit;
    logic               frame_ok;

    logic [SUM_W-1:0]   rem;
    logic [CNT_W-1:0]   div_cnt;
    logic [GRAY_W-1:0]  quot;
    logic [IDX_W-1:0]   div_idx;
    logic [SUM_W-1:0]   div_shift;
    logic               div_ge;
    logic               auto_path;
    logic               pend;

    logic signed [GRAY_W+1:0] thr_sum;
    logic [GRAY_W-1:0]  thr_clamp;
    logic               upd_manual;
    logic               upd_auto;
    logic               upd_drop;

    assign vs_edge    = VGA_VS & ~vs_d;
    assign frame_edge = vs_edge & armed;
    assign pix_take   = armed & GRAY_VALID & ~vs_edge;
    assign cnt_full   = &cnt_acc;
    assign white_full = &white_acc;
    assign sat_hit    = pix_take & (cnt_full | (BINARY_FLAG_IN & white_full));
    assign frame_ok   = (cnt_acc >= CNT_W'(MIN_PIXELS)) & ~bad_acc;

    assign div_shift  = SUM_W'(div_cnt) << div_idx;
    assign div_ge     = (rem >= div_shift);

    // Mean plus signed offset, with two guard bits so both under- and overflow are visible
    assign thr_sum = $signed({2'b00, quot}) + $signed({OFFSET[GRAY_W], OFFSET});

    always_comb begin
        thr_clamp = thr_sum[GRAY_W-1:0];
        if (thr_sum[GRAY_W+1]) begin
            thr_clamp = '0;
        end else if (thr_sum[GRAY_W]) begin
            thr_clamp = '1;
        end
    end

    assign upd_manual = ~MODE_AUTO;
    assign upd_auto   = MODE_AUTO & auto_path;
    assign upd_drop   = (MODE_AUTO & ~auto_path) | pend | frame_edge;
    assign BUSY       = (state != S_WAIT);

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (frame_edge) begin
                    state_nxt = (MODE_AUTO && frame_ok) ? S_DIV : S_UPD;
                end
            end
            S_DIV: begin
                if (div_idx == '0) begin
                    state_nxt = S_UPD;
                end
            end
            S_UPD:   state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    // A pixel valid on the edge cycle belongs to the frame that is just starting
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vs_d      <= 1'b0;
            armed     <= 1'b0;
            sum_acc   <= '0;
            cnt_acc   <= '0;
            white_acc <= '0;
            bad_acc   <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            vs_d <= VGA_VS;
            if (vs_edge) begin
                armed     <= 1'b1;
                sum_acc   <= (GRAY_VALID && armed) ? SUM_W'(GRAY_IN) : '0;
                cnt_acc   <= (GRAY_VALID && armed) ? CNT_W'(1) : '0;
                white_acc <= (GRAY_VALID && armed && BINARY_FLAG_IN) ? CNT_W'(1) : '0;
                bad_acc   <= 1'b0;
            end else if (pix_take) begin
                if (!cnt_full) begin
                    cnt_acc <= cnt_acc + CNT_W'(1);
                    sum_acc <= sum_acc + SUM_W'(GRAY_IN);
                end
                if (BINARY_FLAG_IN && !white_full) begin
                    white_acc <= white_acc + CNT_W'(1);
                end
                if (sat_hit) begin
                    bad_acc  <= 1'b1;
                    OVERFLOW <= 1'b1;
                end
            end
        end
    end

    // Restoring divider shifts the quotient in MSB first; edges while busy only mark a drop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= S_WAIT;
            rem              <= '0;
            div_cnt          <= '0;
            quot             <= '0;
            div_idx          <= '0;
            auto_path        <= 1'b0;
            pend             <= 1'b0;
            THRESHOLD_OUT    <= GRAY_W'(THR_INIT);
            THRESHOLD_UPDATE <= 1'b0;
            MEAN_OUT         <= '0;
            WHITE_COUNT      <= '0;
            FRAME_DROP       <= 1'b0;
        end else begin
            state            <= state_nxt;
            THRESHOLD_UPDATE <= 1'b0;
            FRAME_DROP       <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (frame_edge) begin
                        WHITE_COUNT <= white_acc;
                        rem         <= sum_acc;
                        div_cnt     <= cnt_acc;
                        quot        <= '0;
                        div_idx     <= IDX_W'(GRAY_W - 1);
                        auto_path   <= MODE_AUTO & frame_ok;
                        pend        <= 1'b0;
                    end
                end
                S_DIV: begin
                    if (div_ge) begin
                        rem <= rem - div_shift;
                    end
                    quot    <= {quot[GRAY_W-2:0], div_ge};
                    div_idx <= div_idx - IDX_W'(1);
                    if (frame_edge) begin
                        pend <= 1'b1;
                    end
                end
                S_UPD: begin
                    if (upd_manual) begin
                        THRESHOLD_OUT    <= MANUAL_THRESHOLD;
                        THRESHOLD_UPDATE <= 1'b1;
                    end else if (upd_auto) begin
                        THRESHOLD_OUT    <= thr_clamp;
                        MEAN_OUT         <= quot;
                        THRESHOLD_UPDATE <= 1'b1;
                    end
                    FRAME_DROP <= upd_drop;
                    pend       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_threshold_ctrl.sv
// Self-checking bench for binary_threshold_ctrl: table of whole-frame vectors, hand-written
// corner sequences, then random frames checked against a frame-level arithmetic model.
module tb_binary_threshold_ctrl;

    localparam int GRAY_W = 8;
    localparam int CNT_W  = 22;

    logic              CLK = 1'b0;
    logic              RST;
    logic              VGA_VS;
    logic              GRAY_VALID;
    logic [GRAY_W-1:0] GRAY_IN;
    logic              BINARY_FLAG_IN;
    logic              MODE_AUTO;
    logic [GRAY_W-1:0] MANUAL_THRESHOLD;
    logic [GRAY_W:0]   OFFSET;
    logic [GRAY_W-1:0] THRESHOLD_OUT;
    logic              THRESHOLD_UPDATE;
    logic [GRAY_W-1:0] MEAN_OUT;
    logic [CNT_W-1:0]  WHITE_COUNT;
    logic              BUSY;
    logic              FRAME_DROP;
    logic              OVERFLOW;

    binary_threshold_ctrl #(
        .GRAY_W(GRAY_W), .CNT_W(CNT_W), .THR_INIT(128), .MIN_PIXELS(1)
    ) dut (
        .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .GRAY_VALID(GRAY_VALID), .GRAY_IN(GRAY_IN),
        .BINARY_FLAG_IN(BINARY_FLAG_IN), .MODE_AUTO(MODE_AUTO),
        .MANUAL_THRESHOLD(MANUAL_THRESHOLD), .OFFSET(OFFSET),
        .THRESHOLD_OUT(THRESHOLD_OUT), .THRESHOLD_UPDATE(THRESHOLD_UPDATE),
        .MEAN_OUT(MEAN_OUT), .WHITE_COUNT(WHITE_COUNT), .BUSY(BUSY),
        .FRAME_DROP(FRAME_DROP), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit auto_m;
        int offset;
        int man;
        int gray;
        int npix;
        int nwhite;
        int exp_lat;
        int exp_upd;
        int exp_drop;
        int exp_thr;
        int exp_mean;
        int exp_white;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;
    int   fg[$];
    bit   fw[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives the queued pixels, optionally with random DE gaps, then one idle cycle
    task automatic apply_stimulus(input bit gaps);
        for (int i = 0; i < fg.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                GRAY_VALID = 1'b0;
                tick();
            end
            GRAY_VALID     = 1'b1;
            GRAY_IN        = 8'(fg[i]);
            BINARY_FLAG_IN = fw[i];
            tick();
        end
        GRAY_VALID     = 1'b0;
        BINARY_FLAG_IN = 1'b0;
        GRAY_IN        = '0;
        tick();
    endtask

    task automatic frame_edge(input bit seed, input int seed_gray, input bit seed_white);
        VGA_VS = 1'b1;
        if (seed) begin
            GRAY_VALID     = 1'b1;
            GRAY_IN        = 8'(seed_gray);
            BINARY_FLAG_IN = seed_white;
        end
        tick();
        VGA_VS         = 1'b0;
        GRAY_VALID     = 1'b0;
        BINARY_FLAG_IN = 1'b0;
    endtask

    task automatic wait_result(input int limit, output int lat, output int upd, output int drp);
        lat = -1;
        upd = 0;
        drp = 0;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (THRESHOLD_UPDATE || FRAME_DROP) begin
                lat = n;
                upd = int'(THRESHOLD_UPDATE);
                drp = int'(FRAME_DROP);
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int e_lat, input int e_upd, input int e_drop,
                               input int e_thr, input int e_mean, input int e_white);
        int lat, upd, drp;
        wait_result(20, lat, upd, drp);
        check_output({tag, " latency"}, lat, e_lat);
        check_output({tag, " THRESHOLD_UPDATE"}, upd, e_upd);
        check_output({tag, " FRAME_DROP"}, drp, e_drop);
        check_output({tag, " THRESHOLD_OUT"}, int'(THRESHOLD_OUT), e_thr);
        check_output({tag, " MEAN_OUT"}, int'(MEAN_OUT), e_mean);
        check_output({tag, " WHITE_COUNT"}, int'(WHITE_COUNT), e_white);
        tick();
        check_output({tag, " pulse width"}, int'(THRESHOLD_UPDATE) + int'(FRAME_DROP), 0);
    endtask

    initial begin
        int lat, upd, drp;
        int m_thr, m_mean, off, man, n, sum, w, g, t;
        bit am, b;

        vecs[0] = '{1'b1,    0,  0, 200, 100, 40, 9, 1, 0, 200, 200, 40};
        vecs[1] = '{1'b1,   20,  0, 250,  10,  0, 9, 1, 0, 255, 250,  0};
        vecs[2] = '{1'b1,  -30,  0,  10,   5,  5, 9, 1, 0,   0,  10,  5};
        vecs[3] = '{1'b1,    0,  0,   0,   0,  0, 1, 0, 1,   0,  10,  0};
        vecs[4] = '{1'b0,    0, 33,  50,   8,  3, 1, 1, 0,  33,  10,  3};
        vecs[5] = '{1'b1,    5,  0, 100,  16, 16, 9, 1, 0, 105, 100, 16};
        vecs[6] = '{1'b1, -128,  0, 255,   3,  1, 9, 1, 0, 127, 255,  1};
        vecs[7] = '{1'b1,  255,  0,   0,   4,  0, 9, 1, 0, 255,   0,  0};

        RST = 1'b1; VGA_VS = 1'b0; GRAY_VALID = 1'b0; GRAY_IN = '0; BINARY_FLAG_IN = 1'b0;
        MODE_AUTO = 1'b1; MANUAL_THRESHOLD = '0; OFFSET = '0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check_output("reset THRESHOLD_OUT", int'(THRESHOLD_OUT), 128);
        check_output("reset flags", int'(THRESHOLD_UPDATE) + int'(FRAME_DROP) + int'(BUSY) + int'(OVERFLOW), 0);
        check_output("reset MEAN_OUT", int'(MEAN_OUT), 0);
        check_output("reset WHITE_COUNT", int'(WHITE_COUNT), 0);

        // Pixels before the first edge must not reach any frame statistics
        fg.delete(); fw.delete();
        for (int i = 0; i < 7; i++) begin fg.push_back(0); fw.push_back(1'b1); end
        apply_stimulus(1'b0);
        frame_edge(1'b0, 0, 1'b0);
        wait_result(12, lat, upd, drp);
        check_output("arm edge pulse", lat, -1);
        check_output("arm THRESHOLD_OUT", int'(THRESHOLD_OUT), 128);
        check_output("arm WHITE_COUNT", int'(WHITE_COUNT), 0);

        for (int k = 0; k < 8; k++) begin
            MODE_AUTO        = vecs[k].auto_m;
            OFFSET           = 9'(vecs[k].offset);
            MANUAL_THRESHOLD = 8'(vecs[k].man);
            fg.delete(); fw.delete();
            for (int i = 0; i < vecs[k].npix; i++) begin
                fg.push_back(vecs[k].gray);
                fw.push_back(i < vecs[k].nwhite);
            end
            apply_stimulus(1'b0);
            frame_edge(1'b0, 0, 1'b0);
            check_frame($sformatf("vec%0d", k), vecs[k].exp_lat, vecs[k].exp_upd, vecs[k].exp_drop,
                        vecs[k].exp_thr, vecs[k].exp_mean, vecs[k].exp_white);
        end

        // Floor mean of {10,11,11}; the pixel on the edge cycle opens the next frame
        MODE_AUTO = 1'b1; OFFSET = '0;
        fg = '{10, 11, 11}; fw = '{1'b1, 1'b0, 1'b1};
        apply_stimulus(1'b0);
        frame_edge(1'b1, 255, 1'b1);
        check_frame("floor", 9, 1, 0, 10, 10, 2);
        fg = '{0, 0, 0}; fw = '{1'b0, 1'b0, 1'b0};
        apply_stimulus(1'b0);
        frame_edge(1'b0, 0, 1'b0);
        check_frame("seeded", 9, 1, 0, 63, 63, 1);

        // Manual threshold changed mid-frame only lands one cycle after the edge
        MODE_AUTO = 1'b0; MANUAL_THRESHOLD = 8'd12;
        fg = '{90, 90, 90}; fw = '{1'b0, 1'b0, 1'b0};
        apply_stimulus(1'b0);
        MANUAL_THRESHOLD = 8'd77;
        check_output("manual midframe hold", int'(THRESHOLD_OUT), 63);
        apply_stimulus(1'b0);
        check_output("manual preedge hold", int'(THRESHOLD_OUT), 63);
        frame_edge(1'b0, 0, 1'b0);
        check_output("manual at edge hold", int'(THRESHOLD_OUT), 63);
        check_output("manual BUSY", int'(BUSY), 1);
        tick();
        check_output("manual THRESHOLD_OUT", int'(THRESHOLD_OUT), 77);
        check_output("manual THRESHOLD_UPDATE", int'(THRESHOLD_UPDATE), 1);
        check_output("manual MEAN_OUT", int'(MEAN_OUT), 63);
        check_output("manual WHITE_COUNT", int'(WHITE_COUNT), 0);
        tick();
        check_output("manual after pulse", int'(THRESHOLD_UPDATE) + int'(BUSY), 0);

        // Asynchronous reset in the middle of a division
        MODE_AUTO = 1'b1; OFFSET = 9'd3;
        fg = '{40, 40, 40, 40}; fw = '{1'b1, 1'b1, 1'b0, 1'b0};
        apply_stimulus(1'b0);
        frame_edge(1'b0, 0, 1'b0);
        repeat (3) tick();
        check_output("mid div BUSY", int'(BUSY), 1);
        #2 RST = 1'b1;
        #1;
        check_output("async reset THRESHOLD_OUT", int'(THRESHOLD_OUT), 128);
        check_output("async reset BUSY", int'(BUSY), 0);
        check_output("async reset WHITE_COUNT", int'(WHITE_COUNT), 0);
        #2 RST = 1'b0;
        wait_result(12, lat, upd, drp);
        check_output("post reset no update", lat, -1);
        check_output("post reset THRESHOLD_OUT", int'(THRESHOLD_OUT), 128);

        fg.delete(); fw.delete();
        frame_edge(1'b0, 0, 1'b0);
        wait_result(12, lat, upd, drp);
        check_output("rearm pulse", lat, -1);
        m_thr  = 128;
        m_mean = 0;

        for (int r = 0; r < 14; r++) begin
            am  = ($urandom_range(0, 3) != 0);
            off = int'($urandom_range(0, 511)) - 256;
            man = int'($urandom_range(0, 255));
            n   = (r == 4) ? 0 : int'($urandom_range(0, 20));
            sum = 0;
            w   = 0;
            fg.delete(); fw.delete();
            for (int i = 0; i < n; i++) begin
                g = int'($urandom_range(0, 255));
                b = 1'($urandom_range(0, 1));
                fg.push_back(g);
                fw.push_back(b);
                sum += g;
                w   += int'(b);
            end
            MODE_AUTO        = am;
            OFFSET           = 9'(off);
            MANUAL_THRESHOLD = 8'(man);
            apply_stimulus(1'b1);
            frame_edge(1'b0, 0, 1'b0);
            if (!am) begin
                m_thr = man;
                check_frame($sformatf("rand%0d", r), 1, 1, 0, m_thr, m_mean, w);
            end else if (n == 0) begin
                check_frame($sformatf("rand%0d", r), 1, 0, 1, m_thr, m_mean, w);
            end else begin
                m_mean = sum / n;
                t      = m_mean + off;
                m_thr  = (t < 0) ? 0 : ((t > 255) ? 255 : t);
                check_frame($sformatf("rand%0d", r), 9, 1, 0, m_thr, m_mean, w);
            end
        end

        check_output("final OVERFLOW", int'(OVERFLOW), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/binary_threshold_ctrl.md
Name: binary_threshold_ctrl

Overview:
- Per-frame threshold controller for the gray-to-binary pixel stage.
- Accumulates gray statistics over each frame's active pixels and computes the mean luminance at the frame boundary with a sequential divider.
- Issues the next frame's THRESHOLD as the clamped value mean+OFFSET (auto mode) or MANUAL_THRESHOLD (manual mode).
- Also reports the per-frame white-pixel count for downstream motion-capture logic.

Parameters:
- GRAY_W, 8, gray/threshold width; divider iterations = GRAY_W.
- CNT_W, 22, pixel and white counter width (up to 4M pixels/frame).
- THR_INIT, 128, THRESHOLD_OUT value after reset.
- MIN_PIXELS, 1, minimum active pixels for an auto update to be valid.

Ports:
- CLK  in  1  pixel clock.
- RST  in  1  asynchronous reset, active-high.
- VGA_VS  in  1  frame sync, level; rising edge marks a frame boundary.
- GRAY_VALID  in  1  active-pixel qualifier (DE).
- GRAY_IN  in  GRAY_W  gray pixel value.
- BINARY_FLAG_IN  in  1  binarised pixel (1 = white), qualified by GRAY_VALID.
- MODE_AUTO  in  1  1 = auto threshold, 0 = manual.
- MANUAL_THRESHOLD  in  GRAY_W  manual-mode threshold.
- OFFSET  in  GRAY_W+1  signed two's-complement offset added to the mean.
- THRESHOLD_OUT  out  GRAY_W  registered threshold to the binariser.
- THRESHOLD_UPDATE  out  1  one-cycle pulse when THRESHOLD_OUT is updated.
- MEAN_OUT  out  GRAY_W  last computed frame mean.
- WHITE_COUNT  out  CNT_W  last frame's white-pixel count.
- BUSY  out  1  high during DIV and UPD.
- FRAME_DROP  out  1  one-cycle pulse when a frame's statistics are discarded.
- OVERFLOW  out  1  sticky counter saturation flag; cleared only by RST.

Behaviour:
- Reset (async, RST=1): THRESHOLD_OUT=THR_INIT; all other outputs 0; accumulators cleared; armed=0; FSM=S_WAIT.
- VS edge detect: registered VS_d. Edge at clock E0 means VGA_VS=1 and VS_d=0 at E0.
- armed: set by the first edge. Pixels seen before armed=1 are ignored (partial first frame).
- Accumulation, while armed and GRAY_VALID=1:
  - sum += GRAY_IN; sum width is CNT_W+GRAY_W.
  - cnt += 1.
  - white += BINARY_FLAG_IN.
- Saturation: cnt and white saturate at all-ones. Saturation sets OVERFLOW and marks the frame bad.
- Edge at E0 in S_WAIT with armed=1:
  - Snapshot sum/cnt/white/bad into shadow registers.
  - Clear accumulators. A pixel valid at E0 seeds the new frame (sum=GRAY_IN, cnt=1).
  - WHITE_COUNT <= white snapshot at E0.
  - Go to S_DIV if the frame is usable, else S_UPD with skip flag.
  - The first arming edge only arms; there is no snapshot.
- Frame usability:
  - Auto mode: frame needs cnt>=MIN_PIXELS and bad=0; otherwise skip.
  - Manual mode never skips. It goes directly to S_UPD at E1 with no DIV.
- S_DIV (auto, E1..E8): restoring long division, one quotient bit per cycle, MSB first.
  - Start: rem = sum snapshot.
  - Bit i: if rem >= (cnt<<i), then rem -= cnt<<i and q[i]=1.
  - Quotient fits GRAY_W because sum < 2^GRAY_W·cnt. Result is floor(sum/cnt).
- S_UPD (one cycle):
  - Auto, not skipped: MEAN_OUT<=q; THRESHOLD_OUT<=clamp(q+OFFSET, 0, 2^GRAY_W−1), computed GRAY_W+2 bits signed; THRESHOLD_UPDATE=1.
  - Manual: THRESHOLD_OUT<=MANUAL_THRESHOLD; THRESHOLD_UPDATE=1; MEAN_OUT unchanged.
  - Auto, skipped: THRESHOLD_OUT and MEAN_OUT unchanged; no update pulse; FRAME_DROP=1.
  - Then return to S_WAIT.
- Latency, auto: edge at E0 → S_UPD at E9 → new THRESHOLD_OUT and pulse visible after E9.
- Latency, manual: edge at E0 → update visible after E1.
- Edge while BUSY: accumulators are still snapshotted into a pending slot. The in-flight computation completes. Pending-slot data is discarded with FRAME_DROP at S_UPD, and the FSM returns to S_WAIT; there is no queueing.
- MODE_AUTO and OFFSET are sampled at S_UPD. MODE_AUTO is also sampled at E0 to choose the DIV or manual path.
- THRESHOLD_OUT changes only in S_UPD, so the binariser sees a constant threshold within a frame.

Test Plan:
- Reset, then no VS → THRESHOLD_OUT=128, all flags 0; a pixel burst before the first edge does not change the stats.
- Auto: arm; frame of 100 pixels with GRAY_IN=200, 40 of them BINARY_FLAG_IN=1; OFFSET=0; edge → MEAN_OUT=200, THRESHOLD_OUT=200, pulse exactly 9 cycles after the edge, WHITE_COUNT=40.
- Auto clamp: frame mean 250 with OFFSET=+20 → THRESHOLD_OUT=255. Frame mean 10 with OFFSET=−30 → THRESHOLD_OUT=0.
- Non-integer mean: pixels {10,11,11} → MEAN_OUT=10 (floor). A pixel valid on the edge cycle is counted in the next frame.
- Empty frame in auto mode (no GRAY_VALID between edges) → FRAME_DROP pulse, no THRESHOLD_UPDATE, THRESHOLD_OUT unchanged.
- Manual mode: MANUAL_THRESHOLD=77 changed mid-frame → THRESHOLD_OUT stays at its old value until the edge, becomes 77 one cycle after it. RST asserted mid-DIV → immediate return to THR_INIT, BUSY=0.
